// File: rtl/ysyx_25050147_core_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25050147_core_ctrl
//
// Multi-cycle sequencer for the NPC core. It walks each instruction through
// fetch, execute, optional load/store and writeback. Fetch and load/store
// share one memory port, and only the current state decides which of them
// owns it. PC and register-file writes are strobed only in writeback. An
// ebreak halts the core.
//
// Optional feature (macro CORE_CTRL_WDOG_EN):
//   A watchdog counts the cycles spent waiting in the memory states. When it
//   reaches TIMEOUT_CYC, the core sets err and halts. When the macro is
//   undefined, a wait state may stall forever. In that build, only a
//   misaligned fetch sets err.
//
// Parameters:
//   AW           memory address width
//   TIMEOUT_CYC  watchdog limit in cycles (watchdog build only)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_pc                       current PC
//   o_mem_valid/we/addr/wdata/wmask, i_mem_ready
//                              request side of the shared memory port
//   i_mem_rvalid, i_mem_rdata  read response (one-cycle pulse)
//   o_inst                     latched instruction for the IDU
//   i_dec_load/store/ebreak    decode flags of the current instruction
//   i_ls_addr/wdata/wmask      load/store address, lane-aligned data, mask
//   o_load_data                latched raw load word
//   o_pc_we, o_rf_we           writeback strobes
//   o_halted, o_err            sticky halt / error flags
//   o_inst_cnt                 retired instruction count (wraps)
// ---------------------------------------------------------------------------
module ysyx_25050147_core_ctrl #(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   i_pc,
  output logic          o_mem_valid,
  input  logic          i_mem_ready,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_wmask,
  input  logic          i_mem_rvalid,
  input  logic [31:0]   i_mem_rdata,
  output logic [31:0]   o_inst,
  input  logic          i_dec_load,
  input  logic          i_dec_store,
  input  logic          i_dec_ebreak,
  input  logic [31:0]   i_ls_addr,
  input  logic [31:0]   i_ls_wdata,
  input  logic [3:0]    i_ls_wmask,
  output logic [31:0]   o_load_data,
  output logic          o_pc_we,
  output logic          o_rf_we,
  output logic          o_halted,
  output logic          o_err,
  output logic [31:0]   o_inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_REQ,
    S_F_WAIT,
    S_EXEC,
    S_M_REQ,
    S_M_WAIT,
    S_WB,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_set_err;
  logic        w_misaligned;
  logic [31:0] r_inst;
  logic [31:0] r_load_data;
  logic        r_err;
  logic [31:0] r_inst_cnt;

  assign w_misaligned = (i_pc[1:0] != 2'b00);

`ifdef CORE_CTRL_WDOG_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYC);
  logic [7:0] r_wdog;
  logic       w_wait_state;

  assign w_wait_state = (r_state == S_F_REQ) || (r_state == S_F_WAIT) ||
                        (r_state == S_M_REQ) || (r_state == S_M_WAIT);
`endif

  // Next-state and port drive. Every request field is a pure function of
  // the state and stable inputs, so a request stays stable while it waits
  // for mem_ready. An asynchronous reset also removes mem_valid at once.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned and infer a
    // latch.
    w_next      = r_state;
    w_set_err   = 1'b0;
    o_mem_valid = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wmask = '0;
    o_pc_we     = 1'b0;
    o_rf_we     = 1'b0;

    unique case (r_state)
      S_IDLE: w_next = S_F_REQ;
      S_F_REQ: begin
        if (w_misaligned) begin
          // No request is issued for a misaligned PC. The core stops.
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end else begin
          o_mem_valid = 1'b1;
          o_mem_addr  = AW'(i_pc);
          if (i_mem_ready) w_next = S_F_WAIT;
        end
      end
      S_F_WAIT: if (i_mem_rvalid) w_next = S_EXEC;
      S_EXEC: begin
        if (i_dec_ebreak)                   w_next = S_HALT;
        else if (i_dec_load || i_dec_store) w_next = S_M_REQ;
        else                                w_next = S_WB;
      end
      S_M_REQ: begin
        o_mem_valid = 1'b1;
        o_mem_we    = i_dec_store;
        o_mem_addr  = AW'(i_ls_addr);
        o_mem_wdata = i_ls_wdata;
        o_mem_wmask = i_ls_wmask;
        // A store is finished once it is accepted. A read must wait for its data.
        if (i_mem_ready) w_next = i_dec_store ? S_WB : S_M_WAIT;
      end
      S_M_WAIT: if (i_mem_rvalid) w_next = S_WB;
      S_WB: begin
        o_pc_we = 1'b1;
        o_rf_we = !i_dec_store;
        w_next  = S_F_REQ;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase

`ifdef CORE_CTRL_WDOG_EN
    // Only a state that is about to keep waiting can time out. A state that
    // leaves in this same cycle has made progress.
    if (w_wait_state && (w_next == r_state) && (r_wdog == LP_TIMEOUT)) begin
      w_next    = S_HALT;
      w_set_err = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments, so every register
  // samples values from before the clock edge, whatever order the blocks
  // run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_inst      <= '0;
      r_load_data <= '0;
      r_err       <= 1'b0;
      r_inst_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_err) r_err <= 1'b1;
      // Responses count only in their wait state. A stray rvalid elsewhere is dropped.
      if ((r_state == S_F_WAIT) && i_mem_rvalid) r_inst      <= i_mem_rdata;
      if ((r_state == S_M_WAIT) && i_mem_rvalid) r_load_data <= i_mem_rdata;
      if (r_state == S_WB) r_inst_cnt <= r_inst_cnt + 32'd1;
    end
  end

`ifdef CORE_CTRL_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (!w_wait_state || (w_next != r_state)) begin
      r_wdog <= '0;
    end else if (r_wdog != 8'hFF) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end
`endif

  assign o_inst      = r_inst;
  assign o_load_data = r_load_data;
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = r_err;
  assign o_inst_cnt  = r_inst_cnt;

endmodule

// File: tb/tb_ysyx_25050147_core_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25050147_core_ctrl
//
// Directed bench for the core sequencer. A small memory responder accepts
// requests whenever mem_ready is high. For each accepted read, it returns
// one rvalid pulse in the following cycle. The responder returns the fetch
// word when the address equals the PC, and the load word otherwise.
//
// Timing reference: rst_n is released on a falling edge, and the clock
// period that follows is cycle 1 (IDLE). Cycle n is sampled at the falling
// edge that ends it.
// ---------------------------------------------------------------------------
module tb_ysyx_25050147_core_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_pc = 32'h8000_0000;
  logic        o_mem_valid;
  logic        i_mem_ready = 1'b1;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = 32'h0;
  logic [31:0] o_inst;
  logic        i_dec_load = 1'b0;
  logic        i_dec_store = 1'b0;
  logic        i_dec_ebreak = 1'b0;
  logic [31:0] i_ls_addr = 32'h0;
  logic [31:0] i_ls_wdata = 32'h0;
  logic [3:0]  i_ls_wmask = 4'h0;
  logic [31:0] o_load_data;
  logic        o_pc_we;
  logic        o_rf_we;
  logic        o_halted;
  logic        o_err;
  logic [31:0] o_inst_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] fetch_word = 32'h0010_0093;
  logic [31:0] load_word  = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_data = 32'h0;

  ysyx_25050147_core_ctrl #(.AW(32), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pc         (i_pc),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_inst       (o_inst),
    .i_dec_load   (i_dec_load),
    .i_dec_store  (i_dec_store),
    .i_dec_ebreak (i_dec_ebreak),
    .i_ls_addr    (i_ls_addr),
    .i_ls_wdata   (i_ls_wdata),
    .i_ls_wmask   (i_ls_wmask),
    .o_load_data  (o_load_data),
    .o_pc_we      (o_pc_we),
    .o_rf_we      (o_rf_we),
    .o_halted     (o_halted),
    .o_err        (o_err),
    .o_inst_cnt   (o_inst_cnt)
  );

  always #5 clk = ~clk;

  // Memory responder. A read accepted at rising edge k returns its data
  // through the rising edge k+1.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend         = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 32'h0;
    end else begin
      i_mem_rvalid = pend;
      i_mem_rdata  = pend ? pend_data : 32'h0;
      pend         = o_mem_valid && i_mem_ready && !o_mem_we;
      pend_data    = (o_mem_addr == i_pc) ? fetch_word : load_word;
    end
  end

  task automatic start(input logic [31:0] pc);
    rst_n = 1'b0;
    i_pc  = pc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_dec();
    i_dec_load   = 1'b0;
    i_dec_store  = 1'b0;
    i_dec_ebreak = 1'b0;
    i_mem_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_mem_valid, o_pc_we, o_rf_we, o_halted, o_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got valid/pc_we/rf_we/halted/err=%b want 00000",
               {o_mem_valid, o_pc_we, o_rf_we, o_halted, o_err});
    end
    total++;
    if ({o_inst, o_load_data, o_inst_cnt} !== 96'h0) begin
      bad++;
      $display("FAIL reset_regs: got inst=%h load=%h cnt=%0d want 0/0/0",
               o_inst, o_load_data, o_inst_cnt);
    end
  endtask

  task automatic test_alu();
    int first = 0;
    int pulses = 0;
    clear_dec();
    fetch_word = 32'h0010_0093;
    start(32'h8000_0000);
    while (cyc < 7) begin
      step();
      if (cyc == 2) begin
        total++;
        if (!(o_mem_valid === 1'b1 && o_mem_we === 1'b0 && o_mem_addr === 32'h8000_0000)) begin
          bad++;
          $display("FAIL alu_fetch_req: got valid=%b we=%b addr=%h want 1/0/80000000",
                   o_mem_valid, o_mem_we, o_mem_addr);
        end
      end
      if (o_pc_we === 1'b1) begin
        pulses++;
        if (first == 0) first = cyc;
        total++;
        if (o_rf_we !== 1'b1) begin
          bad++;
          $display("FAIL alu_rf_we: got %b want 1", o_rf_we);
        end
      end
    end
    total++;
    if (first != 5 || pulses != 1) begin
      bad++;
      $display("FAIL alu_latency: got first pc_we cycle %0d pulses %0d want 5/1", first, pulses);
    end
    total++;
    if (o_inst !== 32'h0010_0093 || o_inst_cnt !== 32'd1) begin
      bad++;
      $display("FAIL alu_result: got inst=%h cnt=%0d want 00100093/1", o_inst, o_inst_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen = '0;
    clear_dec();
    start(32'h8000_0000);
    while (cyc < 10) begin
      step();
      if (o_pc_we === 1'b1) seen[cyc] = 1'b1;
    end
    total++;
    if (seen !== 16'h0220) begin
      bad++;
      $display("FAIL b2b_pc_we: got cycle mask %h want 0220 (cycles 5 and 9)", seen);
    end
    total++;
    if (o_inst_cnt !== 32'd2) begin
      bad++;
      $display("FAIL b2b_cnt: got %0d want 2", o_inst_cnt);
    end
  endtask

  task automatic test_load();
    clear_dec();
    i_dec_load = 1'b1;
    i_ls_addr  = 32'h8000_1000;
    load_word  = 32'hDEAD_BEEF;
    start(32'h8000_0000);
    while (cyc < 8) begin
      step();
      if (cyc == 5) begin
        total++;
        if (!(o_mem_valid === 1'b1 && o_mem_we === 1'b0 && o_mem_addr === 32'h8000_1000)) begin
          bad++;
          $display("FAIL load_req: got valid=%b we=%b addr=%h want 1/0/80001000",
                   o_mem_valid, o_mem_we, o_mem_addr);
        end
      end
      if (cyc == 6) begin
        total++;
        if (o_mem_valid !== 1'b0 || o_pc_we !== 1'b0) begin
          bad++;
          $display("FAIL load_wait: got valid=%b pc_we=%b want 0/0", o_mem_valid, o_pc_we);
        end
      end
      if (cyc == 7) begin
        total++;
        if (!(o_pc_we === 1'b1 && o_rf_we === 1'b1 && o_load_data === 32'hDEAD_BEEF)) begin
          bad++;
          $display("FAIL load_wb: got pc_we=%b rf_we=%b data=%h want 1/1/deadbeef",
                   o_pc_we, o_rf_we, o_load_data);
        end
      end
    end
    total++;
    if (o_inst_cnt !== 32'd1) begin
      bad++;
      $display("FAIL load_cnt: got %0d want 1", o_inst_cnt);
    end
  endtask

  task automatic test_store();
    clear_dec();
    i_dec_store = 1'b1;
    i_ls_addr   = 32'h8000_2000;
    i_ls_wdata  = 32'h0000_ABCD;
    i_ls_wmask  = 4'b0011;
    start(32'h8000_0000);
    while (cyc < 7) begin
      step();
      if (cyc == 5) begin
        total++;
        if (!(o_mem_valid === 1'b1 && o_mem_we === 1'b1 && o_mem_addr === 32'h8000_2000 &&
              o_mem_wmask === 4'b0011 && o_mem_wdata === 32'h0000_ABCD)) begin
          bad++;
          $display("FAIL store_req: got valid=%b we=%b addr=%h mask=%b data=%h want 1/1/80002000/0011/0000abcd",
                   o_mem_valid, o_mem_we, o_mem_addr, o_mem_wmask, o_mem_wdata);
        end
      end
      if (cyc == 6) begin
        total++;
        if (o_pc_we !== 1'b1 || o_rf_we !== 1'b0) begin
          bad++;
          $display("FAIL store_wb: got pc_we=%b rf_we=%b want 1/0", o_pc_we, o_rf_we);
        end
      end
      if (cyc == 7) begin
        total++;
        if (!(o_mem_valid === 1'b1 && o_mem_we === 1'b0 && o_mem_addr === 32'h8000_0000 &&
              o_load_data === 32'h0)) begin
          bad++;
          $display("FAIL store_next_fetch: got valid=%b we=%b addr=%h load=%h want 1/0/80000000/0",
                   o_mem_valid, o_mem_we, o_mem_addr, o_load_data);
        end
      end
    end
  endtask

  task automatic test_stall();
    int first = 0;
    int unstable = 0;
    clear_dec();
    i_mem_ready = 1'b0;
    start(32'h8000_0100);
    while (cyc < 11) begin
      step();
      if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h8000_0100 || o_pc_we !== 1'b0)
        unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d unstable cycles of 10 want 0", unstable);
    end
    @(posedge clk);
    #1 i_mem_ready = 1'b1;
    while (cyc < 16) begin
      step();
      if (o_pc_we === 1'b1 && first == 0) first = cyc;
    end
    total++;
    if (first != 15) begin
      bad++;
      $display("FAIL stall_release: got pc_we cycle %0d want 15", first);
    end
  endtask

  task automatic test_ebreak();
    int reqs = 0;
    clear_dec();
    i_dec_ebreak = 1'b1;
    start(32'h8000_0000);
    while (cyc < 4) step();
    total++;
    if (o_halted !== 1'b0) begin
      bad++;
      $display("FAIL ebreak_exec: got halted=%b want 0", o_halted);
    end
    step();
    total++;
    if (o_halted !== 1'b1 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL ebreak_halt: got halted=%b err=%b want 1/0", o_halted, o_err);
    end
    repeat (100) begin
      step();
      if (o_mem_valid !== 1'b0 || o_pc_we !== 1'b0 || o_halted !== 1'b1) reqs++;
    end
    total++;
    if (reqs != 0 || o_inst_cnt !== 32'd0) begin
      bad++;
      $display("FAIL ebreak_quiet: got %0d active cycles cnt=%0d want 0/0", reqs, o_inst_cnt);
    end
  endtask

  task automatic test_misaligned();
    int reqs = 0;
    clear_dec();
    start(32'h8000_0002);
    step();
    total++;
    if (o_mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL misalign_noreq: got valid=%b want 0", o_mem_valid);
    end
    repeat (20) begin
      step();
      if (o_mem_valid !== 1'b0) reqs++;
    end
    total++;
    if (o_halted !== 1'b1 || o_err !== 1'b1 || reqs != 0) begin
      bad++;
      $display("FAIL misalign_halt: got halted=%b err=%b reqs=%0d want 1/1/0", o_halted, o_err, reqs);
    end
  endtask

  // Run right after the misaligned test, so a cleared err also shows that
  // reset reached the sticky flag.
  task automatic test_reset_mid();
    clear_dec();
    i_mem_ready = 1'b0;
    start(32'h8000_0000);
    while (cyc < 4) step();
    total++;
    if (o_mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got valid=%b want 1", o_mem_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_mem_valid !== 1'b0 || o_err !== 1'b0 || o_halted !== 1'b0) begin
      bad++;
      $display("FAIL midrst_drop: got valid=%b err=%b halted=%b want 0/0/0",
               o_mem_valid, o_err, o_halted);
    end
  endtask

  task automatic test_watchdog();
    clear_dec();
    i_mem_ready = 1'b0;
    start(32'h8000_0000);
    repeat (1000) step();
`ifdef CORE_CTRL_WDOG_EN
    total++;
    if (o_err !== 1'b1 || o_halted !== 1'b1 || o_mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL wdog_timeout: got err=%b halted=%b valid=%b want 1/1/0",
               o_err, o_halted, o_mem_valid);
    end
`else
    total++;
    if (o_err !== 1'b0 || o_halted !== 1'b0 || o_mem_valid !== 1'b1) begin
      bad++;
      $display("FAIL no_wdog: got err=%b halted=%b valid=%b want 0/0/1",
               o_err, o_halted, o_mem_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_stall();
    test_ebreak();
    test_misaligned();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
